// File: rtl/fifo_pkg.sv
// Shared constants for the async FIFO benches and the sequential read checker.
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int CSIZE_DEF = 16;
    localparam int GSIZE_DEF = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_GAP  = S_GAP,
        ST_DONE = S_DONE
    } rd_state_t;

endpackage

// File: rtl/fifo_seq_reader_if.sv
// Read port of the async FIFO: the consumer drives rinc, the FIFO drives rempty/rdata.
interface fifo_seq_reader_if #(parameter int DSIZE = fifo_pkg::DSIZE_DEF);

    logic             rinc;
    logic             rempty;
    logic [DSIZE-1:0] rdata;

    modport master (output rinc, input rempty, input rdata);
    modport slave  (input rinc, output rempty, output rdata);

endinterface

// File: rtl/fifo_seq_reader_sat_counter.sv
// Up-counter that sticks at all-ones; clr restarts it from zero.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fifo_seq_reader.sv
// Drains the FIFO read port at a programmable rate and checks for an incrementing data sequence.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | rinc high, accepting a word whenever rempty is low
// GAP   | rinc low for rd_gap cycles after an accepted word
// DONE  | num_words accepted; results held until the next start
module fifo_seq_reader
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int CSIZE = CSIZE_DEF,
    parameter int GSIZE = GSIZE_DEF
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             start,
    input  logic [CSIZE-1:0] num_words,
    input  logic [GSIZE-1:0] rd_gap,
    fifo_seq_reader_if.master rd,
    output logic             busy,
    output logic             done,
    output logic [CSIZE-1:0] rd_cnt,
    output logic [CSIZE-1:0] err_cnt,
    output logic             mismatch,
    output logic [DSIZE-1:0] first_exp,
    output logic [DSIZE-1:0] first_got
);

    rd_state_t        state, state_nxt;
    logic [DSIZE-1:0] exp_q;
    logic [CSIZE-1:0] num_q;
    logic [GSIZE-1:0] gap_q;
    logic [GSIZE-1:0] gcnt;

    logic launch;
    logic accept;
    logic data_err;
    logic last_word;

    assign launch    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign accept    = (state == ST_RUN) && !rd.rempty;
    assign data_err  = accept && (rd.rdata != exp_q);
    assign last_word = (num_q != '0) && ((rd_cnt + CSIZE'(1)) == num_q);

    always_comb begin
        state_nxt = state;
        rd.rinc   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                rd.rinc = 1'b1;
                busy    = 1'b1;
                if (accept) begin
                    if (last_word)          state_nxt = ST_DONE;
                    else if (gap_q != '0)   state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                busy = 1'b1;
                if (gcnt == GSIZE'(1)) state_nxt = ST_RUN;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state     <= ST_IDLE;
            rd_cnt    <= '0;
            exp_q     <= '0;
            num_q     <= '0;
            gap_q     <= '0;
            gcnt      <= '0;
            mismatch  <= 1'b0;
            first_exp <= '0;
            first_got <= '0;
        end else begin
            state    <= state_nxt;
            mismatch <= data_err;
            if (launch) begin
                rd_cnt    <= '0;
                exp_q     <= '0;
                num_q     <= num_words;
                gap_q     <= rd_gap;
                first_exp <= '0;
                first_got <= '0;
            end
            if (accept) begin
                rd_cnt <= rd_cnt + CSIZE'(1);
                // Resync to the received word so a single drop costs one error, not a burst.
                exp_q  <= rd.rdata + DSIZE'(1);
                gcnt   <= gap_q;
                if (data_err && (err_cnt == '0)) begin
                    first_exp <= exp_q;
                    first_got <= rd.rdata;
                end
            end
            if (state == ST_GAP) begin
                gcnt <= gcnt - GSIZE'(1);
            end
        end
    end

    sat_counter #(.W(CSIZE)) u_err_cnt (
        .clk (rclk),
        .rst (rrst),
        .clr (launch),
        .inc (data_err),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_fifo_seq_reader.sv
// Scoreboard bench: a FIFO model feeds the reader, a reference model predicts results, a monitor compares.
module tb_fifo_seq_reader;

    logic rclk = 1'b0;
    always #5 rclk = ~rclk;

    // main DUT (default sizes)
    logic        rrst = 1'b1, start = 1'b0;
    logic [15:0] num_words = '0;
    logic [3:0]  rd_gap = '0;
    logic        busy, done, mismatch;
    logic [15:0] rd_cnt, err_cnt;
    logic [7:0]  first_exp, first_got;

    // narrow-counter DUT for saturation and rd_cnt wrap
    logic        rrst2 = 1'b1, start2 = 1'b0;
    logic [3:0]  num2 = '0, gap2 = '0;
    logic        busy2, done2, mism2;
    logic [3:0]  rd_cnt2, err_cnt2;
    logic [7:0]  fexp2, fgot2;

    fifo_seq_reader_if #(.DSIZE(8)) f1 ();
    fifo_seq_reader_if #(.DSIZE(8)) f2 ();

    fifo_seq_reader #(.DSIZE(8), .CSIZE(16), .GSIZE(4)) dut (
        .rclk(rclk), .rrst(rrst), .start(start), .num_words(num_words), .rd_gap(rd_gap),
        .rd(f1.master), .busy(busy), .done(done), .rd_cnt(rd_cnt), .err_cnt(err_cnt),
        .mismatch(mismatch), .first_exp(first_exp), .first_got(first_got));

    fifo_seq_reader #(.DSIZE(8), .CSIZE(4), .GSIZE(4)) dut2 (
        .rclk(rclk), .rrst(rrst2), .start(start2), .num_words(num2), .rd_gap(gap2),
        .rd(f2.master), .busy(busy2), .done(done2), .rd_cnt(rd_cnt2), .err_cnt(err_cnt2),
        .mismatch(mism2), .first_exp(fexp2), .first_got(fgot2));

    typedef struct {
        logic [15:0] cnt;
        logic [15:0] err;
        logic [7:0]  fexp;
        logic [7:0]  fgot;
        logic        mism;
        logic        busy;
        logic        done;
    } rec_t;

    rec_t        rec_q[$];
    string       chk_name_q[$];
    logic [31:0] chk_got_q[$];
    logic [31:0] chk_exp_q[$];

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (sampled mid-cycle) ----------------
    int          cyc = 0;
    int          pops_total = 0;
    int          start_cyc = 0;
    int          acc_times[$];
    logic [15:0] m_cnt = '0, m_err = '0, m_num = '0;
    logic [7:0]  m_exp = '0, m_fexp = '0, m_fgot = '0, m_d;
    bit          m_run = 0, m_done = 0, m_first = 0, m_mism;

    function automatic rec_t mk_rec(bit mism);
        rec_t r;
        r.cnt = m_cnt; r.err = m_err; r.fexp = m_fexp; r.fgot = m_fgot;
        r.mism = mism; r.busy = m_run; r.done = m_done;
        return r;
    endfunction

    always @(negedge rclk) begin
        cyc = cyc + 1;
        if (rrst) begin
            m_cnt = '0; m_err = '0; m_fexp = '0; m_fgot = '0; m_exp = '0;
            m_run = 0; m_done = 0; m_first = 0;
            rec_q.push_back(mk_rec(1'b0));
        end else if (start && !m_run) begin
            m_cnt = '0; m_err = '0; m_fexp = '0; m_fgot = '0; m_exp = '0;
            m_num = num_words; m_run = 1; m_done = 0; m_first = 0;
            start_cyc = cyc;
            rec_q.push_back(mk_rec(1'b0));
        end else if (f1.rinc && !f1.rempty) begin
            pops_total = pops_total + 1;
            if (m_run) begin
                acc_times.push_back(cyc);
                m_d    = f1.rdata;
                m_cnt  = m_cnt + 16'd1;
                m_mism = (m_d != m_exp);
                if (m_mism) begin
                    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                    if (!m_first) begin
                        m_fexp = m_exp; m_fgot = m_d; m_first = 1;
                    end
                end
                m_exp = m_d + 8'd1;
                if (m_num != 0 && m_cnt == m_num) begin
                    m_run = 0; m_done = 1;
                end
                rec_q.push_back(mk_rec(m_mism));
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic cmp(string name, logic [31:0] got, logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    rec_t last;
    bit   mon_started = 0;
    bit   fresh;

    always @(posedge rclk) begin
        #2;
        fresh = 0;
        if (rec_q.size() > 0) begin
            last = rec_q.pop_front();
            fresh = 1;
            mon_started = 1;
        end
        if (mon_started) begin
            cmp("rd_cnt",    32'(rd_cnt),    32'(last.cnt));
            cmp("err_cnt",   32'(err_cnt),   32'(last.err));
            cmp("first_exp", 32'(first_exp), 32'(last.fexp));
            cmp("first_got", 32'(first_got), 32'(last.fgot));
            cmp("busy",      32'(busy),      32'(last.busy));
            cmp("done",      32'(done),      32'(last.done));
            cmp("mismatch",  32'(mismatch),  32'(fresh && last.mism));
            if (!last.busy) cmp("rinc_idle", 32'(f1.rinc), 32'd0);
        end
        while (chk_name_q.size() > 0) begin
            cmp(chk_name_q.pop_front(), chk_got_q.pop_front(), chk_exp_q.pop_front());
        end
    end

    // ---------------- stimulus / FIFO model ----------------
    logic [7:0] fq[$];
    bit         stall_pat[$];
    int         stall_pct = 0;
    int         pops_done = 0;
    logic [7:0] junk;

    task automatic req_chk(string name, logic [31:0] got, logic [31:0] exp);
        chk_name_q.push_back(name);
        chk_got_q.push_back(got);
        chk_exp_q.push_back(exp);
    endtask

    task automatic tick();
        bit stall;
        @(posedge rclk);
        #1;
        while (pops_done < pops_total) begin
            if (fq.size() > 0) junk = fq.pop_front();
            pops_done = pops_done + 1;
        end
        stall = 0;
        if (stall_pat.size() > 0) stall = stall_pat.pop_front();
        else if (stall_pct > 0) stall = ($urandom_range(99) < stall_pct);
        f1.rempty = stall || (fq.size() == 0);
        f1.rdata  = (fq.size() > 0) ? fq[0] : 8'h00;
    endtask

    task automatic load(int first, int n);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(8'(first + i));
    endtask

    task automatic start_run(int num, int gap);
        num_words = 16'(num);
        rd_gap    = 4'(gap);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(int budget, output int pulses);
        int n;
        pulses = 0;
        n = 0;
        while (!done && n < budget) begin
            tick();
            if (mismatch) pulses++;
            n++;
        end
        if (!done) req_chk("run_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses, base, n;
        logic [7:0] w;
        f1.rempty = 1'b1; f1.rdata = '0;
        f2.rempty = 1'b1; f2.rdata = 8'd5;
        tick(); tick();
        rrst = 1'b0; rrst2 = 1'b0;
        tick();
        req_chk("reset_rinc",  32'(f1.rinc), 0);
        req_chk("reset_busy",  32'(busy), 0);
        req_chk("reset_done",  32'(done), 0);
        req_chk("reset_rdcnt", 32'(rd_cnt), 0);
        req_chk("reset_err",   32'(err_cnt), 0);

        // ideal stream
        load(0, 16);
        base = acc_times.size();
        start_run(16, 0);
        wait_done(100, pulses);
        req_chk("ideal_accepts", acc_times.size() - base, 16);
        req_chk("ideal_first",   acc_times[base] - start_cyc, 1);
        req_chk("ideal_span",    acc_times[base+15] - acc_times[base], 15);
        req_chk("ideal_done_lat", cyc - acc_times[base+15], 0);
        req_chk("ideal_rdcnt",   32'(rd_cnt), 16);
        req_chk("ideal_err",     32'(err_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            req_chk("ideal_no_overread", 32'(f1.rinc), 0);
        end

        // gap
        load(0, 20);
        base = acc_times.size();
        start_run(4, 3);
        wait_done(100, pulses);
        for (int i = 0; i < 4; i++)
            req_chk($sformatf("gap_acc%0d", i), acc_times[base+i] - start_cyc, 1 + 4*i);
        req_chk("gap_rdcnt", 32'(rd_cnt), 4);

        // empty stalls
        load(0, 2);
        stall_pat = '{1, 1, 0, 1, 0};
        base = acc_times.size();
        start_run(2, 0);
        req_chk("stall_rinc0", 32'(f1.rinc), 1);
        tick();
        req_chk("stall_rinc1", 32'(f1.rinc), 1);
        tick(); tick();
        req_chk("stall_rinc3", 32'(f1.rinc), 1);
        tick(); tick();
        req_chk("stall_done",    32'(done), 1);
        req_chk("stall_accepts", acc_times.size() - base, 2);
        req_chk("stall_rdcnt",   32'(rd_cnt), 2);
        req_chk("stall_err",     32'(err_cnt), 0);

        // corruption
        fq = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd8};
        start_run(5, 0);
        wait_done(100, pulses);
        req_chk("corr_err",    32'(err_cnt), 1);
        req_chk("corr_pulses", pulses, 1);
        req_chk("corr_fexp",   32'(first_exp), 3);
        req_chk("corr_fgot",   32'(first_got), 7);

        // data wrap
        fq = '{8'd254, 8'd255, 8'd0, 8'd1};
        start_run(4, 0);
        wait_done(100, pulses);
        req_chk("wrap_err",    32'(err_cnt), 1);
        req_chk("wrap_pulses", pulses, 1);
        req_chk("wrap_fexp",   32'(first_exp), 0);
        req_chk("wrap_fgot",   32'(first_got), 254);

        // reset while in GAP
        load(0, 10);
        base = acc_times.size();
        start_run(10, 2);
        n = 0;
        while (!((acc_times.size() - base) >= 5 && busy && !f1.rinc) && n < 100) begin
            tick();
            n++;
        end
        req_chk("rst_reach_gap", 32'(n < 100), 1);
        req_chk("rst_pre_rdcnt", 32'(rd_cnt), 5);
        rrst = 1'b1;
        tick();
        req_chk("rst_rinc",  32'(f1.rinc), 0);
        req_chk("rst_busy",  32'(busy), 0);
        req_chk("rst_rdcnt", 32'(rd_cnt), 0);
        req_chk("rst_err",   32'(err_cnt), 0);
        rrst = 1'b0;
        load(0, 4);
        start_run(4, 0);
        wait_done(100, pulses);
        req_chk("rst_rerun_rdcnt", 32'(rd_cnt), 4);
        req_chk("rst_rerun_err",   32'(err_cnt), 0);

        // randomized runs with stalls, gaps, drops and a stray start
        stall_pct = 25;
        for (int r = 0; r < 6; r++) begin
            fq.delete();
            w = (r == 0) ? 8'd0 : 8'($urandom_range(255));
            for (int i = 0; i < 48; i++) begin
                fq.push_back(w);
                w = w + 8'd1;
                if ($urandom_range(9) == 0) w = w + 8'($urandom_range(5, 1));
            end
            start_run($urandom_range(20, 1), $urandom_range(3));
            if (r == 2) begin
                tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            wait_done(2000, pulses);
        end
        stall_pct = 0;

        // error saturation and rd_cnt wrap on the narrow instance
        f2.rempty = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1)  req_chk("sat_pulse", 32'(mism2), 1);
            if (i == 14) req_chk("sat_err14", 32'(err_cnt2), 14);
            if (i == 15) req_chk("sat_err15", 32'(err_cnt2), 15);
        end
        req_chk("sat_err20",   32'(err_cnt2), 15);
        req_chk("sat_rdwrap",  32'(rd_cnt2), 4);
        req_chk("sat_busy",    32'(busy2), 1);
        req_chk("sat_fexp",    32'(fexp2), 0);
        req_chk("sat_fgot",    32'(fgot2), 5);
        rrst2 = 1'b1;
        tick();
        req_chk("sat_rst_rinc", 32'(f2.rinc), 0);
        req_chk("sat_rst_err",  32'(err_cnt2), 0);
        rrst2 = 1'b0;
        f2.rempty = 1'b1;

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
